// File: rtl/mips_multicycle_ctrl_if.sv
// Control-side bundle of the multi-cycle MIPS controller: instruction/memory status in,
// datapath steering strobes and debug/status out.
interface mips_multicycle_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       opcode;
    logic             mem_ready;
    logic             pc_write;
    logic             pc_write_cond;
    logic             iord;
    logic             mem_read;
    logic             mem_write;
    logic             ir_write;
    logic             mem_to_reg;
    logic             reg_dst;
    logic             reg_write;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic [1:0]       pc_source;
    logic [3:0]       state_out;
    logic             illegal_op;
    logic [CNT_W-1:0] retired;

    // master = controller, slave = datapath/memory side
    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, state_out, illegal_op, retired
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, state_out, illegal_op, retired
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM of the multi-cycle MIPS core with retired-instruction counter.
// Define MC_CTRL_ADDI_EN to add the addi path (ADDIEX/ADDIWB).
module mips_multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mips_multicycle_ctrl_if.master bus
);
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_JUMP    = 4'd9,
        S_ADDIEX  = 4'd10,
        S_ADDIWB  = 4'd11
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] retired_q;

    logic       pc_write_c, pc_write_cond_c, mem_read_c, mem_write_c, ir_write_c, reg_write_c;
    logic       iord_c, mem_to_reg_c, reg_dst_c, alu_src_a_c, illegal_c, retire_c;
    logic [1:0] alu_src_b_c, alu_op_c, pc_source_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire_c) retired_q <= retired_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d         = state_q;
        pc_write_c      = 1'b0;
        pc_write_cond_c = 1'b0;
        mem_read_c      = 1'b0;
        mem_write_c     = 1'b0;
        ir_write_c      = 1'b0;
        reg_write_c     = 1'b0;
        iord_c          = 1'b0;
        mem_to_reg_c    = 1'b0;
        reg_dst_c       = 1'b0;
        alu_src_a_c     = 1'b0;
        alu_src_b_c     = 2'b00;
        alu_op_c        = 2'b00;
        pc_source_c     = 2'b00;
        illegal_c       = 1'b0;
        retire_c        = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read_c  = 1'b1;
                alu_src_b_c = 2'b01;
                ir_write_c  = bus.mem_ready;
                pc_write_c  = bus.mem_ready;
                if (bus.mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                // ALU precomputes PC + (imm<<2) so BRANCH can use ALUOut
                alu_src_b_c = 2'b11;
                case (bus.opcode)
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
`ifdef MC_CTRL_ADDI_EN
                    OP_ADDI:      state_d = S_ADDIEX;
`endif
                    default: begin
                        illegal_c = 1'b1;
                        state_d   = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a_c = 1'b1;
                alu_src_b_c = 2'b10;
                state_d     = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                mem_read_c = 1'b1;
                iord_c     = 1'b1;
                if (bus.mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                reg_write_c  = 1'b1;
                mem_to_reg_c = 1'b1;
                retire_c     = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEMWR: begin
                mem_write_c = 1'b1;
                iord_c      = 1'b1;
                if (bus.mem_ready) begin
                    retire_c = 1'b1;
                    state_d  = S_FETCH;
                end
            end
            S_EXECUTE: begin
                alu_src_a_c = 1'b1;
                alu_op_c    = 2'b10;
                state_d     = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_c = 1'b1;
                reg_dst_c   = 1'b1;
                retire_c    = 1'b1;
                state_d     = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a_c     = 1'b1;
                alu_op_c        = 2'b01;
                pc_write_cond_c = 1'b1;
                pc_source_c     = 2'b01;
                retire_c        = 1'b1;
                state_d         = S_FETCH;
            end
            S_JUMP: begin
                pc_write_c  = 1'b1;
                pc_source_c = 2'b10;
                retire_c    = 1'b1;
                state_d     = S_FETCH;
            end
`ifdef MC_CTRL_ADDI_EN
            S_ADDIEX: begin
                alu_src_a_c = 1'b1;
                alu_src_b_c = 2'b10;
                state_d     = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write_c = 1'b1;
                retire_c    = 1'b1;
                state_d     = S_FETCH;
            end
`endif
            default: state_d = S_FETCH;
        endcase
    end

    // Strobes are gated by reset so an aborted access never fires
    assign bus.pc_write      = pc_write_c      & rst_n;
    assign bus.pc_write_cond = pc_write_cond_c & rst_n;
    assign bus.mem_read      = mem_read_c      & rst_n;
    assign bus.mem_write     = mem_write_c     & rst_n;
    assign bus.ir_write      = ir_write_c      & rst_n;
    assign bus.reg_write     = reg_write_c     & rst_n;
    assign bus.illegal_op    = illegal_c       & rst_n;
    assign bus.iord          = iord_c;
    assign bus.mem_to_reg    = mem_to_reg_c;
    assign bus.reg_dst       = reg_dst_c;
    assign bus.alu_src_a     = alu_src_a_c;
    assign bus.alu_src_b     = alu_src_b_c;
    assign bus.alu_op        = alu_op_c;
    assign bus.pc_source     = pc_source_c;
    assign bus.state_out     = state_q;
    assign bus.retired       = retired_q;
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: a 32-bit-counter and a 4-bit-counter instance
// share clock, reset and stimulus; the expected state sequence is kept in a queue.
module tb_mips_multicycle_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;

    logic [3:0]  exp_q[$];
    logic [31:0] exp_ret;
    int          pass_cnt = 0;
    int          total_cnt = 0;

    mips_multicycle_ctrl_if #(.CNT_W(32)) bus32 ();
    mips_multicycle_ctrl_if #(.CNT_W(4))  bus4 ();

    assign bus32.opcode    = opcode;
    assign bus32.mem_ready = mem_ready;
    assign bus4.opcode     = opcode;
    assign bus4.mem_ready  = mem_ready;

    mips_multicycle_ctrl #(.CNT_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus32));
    mips_multicycle_ctrl #(.CNT_W(4))  dut_w4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic pop_chk(input string tag);
        logic [3:0] e;
        total_cnt++;
        assert (exp_q.size() != 0) pass_cnt++;
        else $error("FAIL %s: observed empty queue expected a state entry", tag);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk(tag, 32'(bus32.state_out), 32'(e));
        end
    endtask

    task automatic push3(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
        exp_q.push_back(a);
        exp_q.push_back(b);
        exp_q.push_back(c);
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $error("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; opcode = 6'd0; mem_ready = 1'b1; exp_ret = 0;
        @(negedge clk);
        chk("rst_state", 32'(bus32.state_out), 32'd0);
        chk("rst_retired", bus32.retired, 32'd0);
        chk("rst_illegal", 32'(bus32.illegal_op), 32'd0);
        chk("rst_mem_read", 32'(bus32.mem_read), 32'd0);
        chk("rst_ir_write", 32'(bus32.ir_write), 32'd0);
        chk("rst_pc_write", 32'(bus32.pc_write), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("fetch_mem_read", 32'(bus32.mem_read), 32'd1);
        chk("fetch_ir_write", 32'(bus32.ir_write), 32'd1);
        chk("fetch_pc_write", 32'(bus32.pc_write), 32'd1);
        chk("fetch_alu_src_b", 32'(bus32.alu_src_b), 32'd1);

        // R-type: 0,1,6,7
        opcode = 6'b000000;
        push3(4'd0, 4'd1, 4'd6); exp_q.push_back(4'd7);
        pop_chk("r_fetch"); nxt();
        pop_chk("r_decode"); chk("r_dec_alu_src_b", 32'(bus32.alu_src_b), 32'd3); nxt();
        pop_chk("r_exec"); chk("r_alu_op", 32'(bus32.alu_op), 32'd2);
        chk("r_alu_src_a", 32'(bus32.alu_src_a), 32'd1); nxt();
        pop_chk("r_aluwb"); chk("r_reg_write", 32'(bus32.reg_write), 32'd1);
        chk("r_reg_dst", 32'(bus32.reg_dst), 32'd1);
        chk("r_retired_before", bus32.retired, exp_ret); nxt();
        exp_ret = 1; chk("r_retired_after", bus32.retired, exp_ret);

        // lw with two memory-wait cycles: 0,1,2,3,3,3,4
        opcode = 6'b100011;
        push3(4'd0, 4'd1, 4'd2); push3(4'd3, 4'd3, 4'd3); exp_q.push_back(4'd4);
        pop_chk("lw_fetch"); nxt();
        pop_chk("lw_decode"); nxt();
        pop_chk("lw_memadr"); chk("lw_alu_src_b", 32'(bus32.alu_src_b), 32'd2);
        mem_ready = 1'b0; nxt();
        for (int i = 0; i < 3; i++) begin
            pop_chk("lw_memrd");
            chk("lw_mem_read", 32'(bus32.mem_read), 32'd1);
            chk("lw_iord", 32'(bus32.iord), 32'd1);
            if (i == 2) mem_ready = 1'b1;
            nxt();
        end
        pop_chk("lw_memwb"); chk("lw_mem_to_reg", 32'(bus32.mem_to_reg), 32'd1);
        chk("lw_reg_write", 32'(bus32.reg_write), 32'd1);
        chk("lw_reg_dst", 32'(bus32.reg_dst), 32'd0); nxt();
        exp_ret = 2; chk("lw_retired", bus32.retired, exp_ret);

        // sw with one fetch stall: 0,0,1,2,5
        opcode = 6'b101011;
        push3(4'd0, 4'd0, 4'd1); exp_q.push_back(4'd2); exp_q.push_back(4'd5);
        mem_ready = 1'b0; #1;
        chk("sw_stall_ir_write", 32'(bus32.ir_write), 32'd0);
        chk("sw_stall_pc_write", 32'(bus32.pc_write), 32'd0);
        pop_chk("sw_fetch_stall"); nxt();
        pop_chk("sw_fetch"); mem_ready = 1'b1; #1;
        chk("sw_ir_write", 32'(bus32.ir_write), 32'd1); nxt();
        pop_chk("sw_decode"); nxt();
        pop_chk("sw_memadr"); nxt();
        pop_chk("sw_memwr"); chk("sw_mem_write", 32'(bus32.mem_write), 32'd1);
        chk("sw_iord", 32'(bus32.iord), 32'd1);
        chk("sw_mem_read", 32'(bus32.mem_read), 32'd0); nxt();
        exp_ret = 3; chk("sw_retired", bus32.retired, exp_ret);

        // beq: 0,1,8
        opcode = 6'b000100;
        push3(4'd0, 4'd1, 4'd8);
        pop_chk("beq_fetch"); nxt();
        pop_chk("beq_decode"); nxt();
        pop_chk("beq_branch"); chk("beq_alu_op", 32'(bus32.alu_op), 32'd1);
        chk("beq_pc_write_cond", 32'(bus32.pc_write_cond), 32'd1);
        chk("beq_pc_source", 32'(bus32.pc_source), 32'd1);
        chk("beq_pc_write", 32'(bus32.pc_write), 32'd0); nxt();
        exp_ret = 4; chk("beq_retired", bus32.retired, exp_ret);

        // j: 0,1,9
        opcode = 6'b000010;
        push3(4'd0, 4'd1, 4'd9);
        pop_chk("j_fetch"); nxt();
        pop_chk("j_decode"); nxt();
        pop_chk("j_jump"); chk("j_pc_write", 32'(bus32.pc_write), 32'd1);
        chk("j_pc_source", 32'(bus32.pc_source), 32'd2); nxt();
        exp_ret = 5; chk("j_retired", bus32.retired, exp_ret);

        // illegal opcode 111111
        opcode = 6'b111111;
        exp_q.push_back(4'd0); exp_q.push_back(4'd1);
        pop_chk("ill_fetch");
        chk("ill_fetch_flag", 32'(bus32.illegal_op), 32'd0); nxt();
        pop_chk("ill_decode"); chk("ill_flag", 32'(bus32.illegal_op), 32'd1); nxt();
        chk("ill_next_state", 32'(bus32.state_out), 32'd0);
        chk("ill_flag_drop", 32'(bus32.illegal_op), 32'd0);
        chk("ill_retired", bus32.retired, exp_ret);

        // addi 001000
        opcode = 6'b001000;
`ifdef MC_CTRL_ADDI_EN
        push3(4'd0, 4'd1, 4'd10); exp_q.push_back(4'd11);
        pop_chk("addi_fetch"); nxt();
        pop_chk("addi_decode"); nxt();
        pop_chk("addi_ex"); chk("addi_alu_src_b", 32'(bus32.alu_src_b), 32'd2);
        chk("addi_alu_src_a", 32'(bus32.alu_src_a), 32'd1); nxt();
        pop_chk("addi_wb"); chk("addi_reg_write", 32'(bus32.reg_write), 32'd1);
        chk("addi_reg_dst", 32'(bus32.reg_dst), 32'd0); nxt();
        exp_ret = 6; chk("addi_retired", bus32.retired, exp_ret);
`else
        exp_q.push_back(4'd0); exp_q.push_back(4'd1);
        pop_chk("addi_fetch"); nxt();
        pop_chk("addi_decode"); chk("addi_illegal", 32'(bus32.illegal_op), 32'd1); nxt();
        chk("addi_next_state", 32'(bus32.state_out), 32'd0);
        chk("addi_retired", bus32.retired, exp_ret);
`endif

        // reset abort during a stalled MEMWR
        opcode = 6'b101011;
        push3(4'd0, 4'd1, 4'd2); exp_q.push_back(4'd5);
        pop_chk("abort_fetch"); nxt();
        pop_chk("abort_decode"); nxt();
        pop_chk("abort_memadr"); mem_ready = 1'b0; nxt();
        pop_chk("abort_memwr"); chk("abort_mem_write_on", 32'(bus32.mem_write), 32'd1);
        rst_n = 1'b0; #1;
        chk("abort_mem_write_off", 32'(bus32.mem_write), 32'd0);
        chk("abort_state", 32'(bus32.state_out), 32'd0);
        chk("abort_retired", bus32.retired, 32'd0);
        chk("abort_mem_read", 32'(bus32.mem_read), 32'd0);
        nxt();
        rst_n = 1'b1; mem_ready = 1'b1; exp_ret = 0; #1;
        chk("abort_release_state", 32'(bus32.state_out), 32'd0);
        chk("abort_release_retired4", 32'(bus4.retired), 32'd0);

        // 16 jumps: 4-bit counter wraps to 0, 32-bit counter reaches 16
        opcode = 6'b000010;
        for (int i = 0; i < 16; i++) begin
            push3(4'd0, 4'd1, 4'd9);
            pop_chk("wrap_fetch"); nxt();
            pop_chk("wrap_decode"); nxt();
            pop_chk("wrap_jump"); nxt();
            exp_ret = exp_ret + 1;
            chk("wrap_retired4", 32'(bus4.retired), exp_ret % 16);
        end
        chk("wrap_retired32", bus32.retired, 32'd16);
        chk("wrap_retired4_zero", 32'(bus4.retired), 32'd0);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
